// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg: shared constants and helpers for the 7-segment scan path.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int CODE_W     = 4;
  localparam int MAX_DIGITS = 8;

  // Wide enough for the largest display; callers slice to their digit count.
  localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_lz_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_lz_mask: per-digit suppress mask from disabled and leading-zero  |
// | digits. Revision: 1.0                                                |
// +----------------------------------------------------------------------+
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic [CODE_W*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]        en,
  output logic [NUM_DIGITS-1:0]        suppress
);

  // Walk from the most significant digit down; disabled digits do not
  // break a run of leading zeros. Digit 0 is only ever blanked when disabled.
  always_comb begin
    logic zero_above;
    suppress   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (~en[i] | (codes[i*CODE_W +: CODE_W] == '0));
      suppress[i] = ~en[i] | ((LZ_SUPPRESS != 0) && (i != 0) && zero_above);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl: time-multiplexed digit scanner with frame snapshots,  |
// | anti-ghosting blank window and leading-zero blanking. Revision: 1.0  |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int SCAN_HZ     = 1000,
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_CYC   = 64,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W*NUM_DIGITS-1:0] digit_vals,
  input  logic [NUM_DIGITS-1:0]        digit_en,
  output logic [CODE_W-1:0]            cur_code,
  output logic [NUM_DIGITS-1:0]        dig_sel,
  output logic                         blank,
  output logic                         frame_start
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PSC_W = clog2(DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);

  localparam logic [PSC_W-1:0]      PSC_LAST  = PSC_W'(DIV - 1);
  localparam logic [PSC_W-1:0]      PSC_BLANK = PSC_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = DIG_OFF[NUM_DIGITS-1:0];

  logic [PSC_W-1:0]             psc_q, psc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         first_q, first_d;
  logic [CODE_W*NUM_DIGITS-1:0] snap_vals_q, snap_vals_d;
  logic [NUM_DIGITS-1:0]        snap_en_q, snap_en_d;
  logic [CODE_W-1:0]            cur_code_q, cur_code_d;
  logic [NUM_DIGITS-1:0]        dig_sel_q, dig_sel_d;
  logic                         blank_q, blank_d;
  logic                         frame_start_q, frame_start_d;

  logic                         slot_end;
  logic                         take_snap;
  logic [CODE_W*NUM_DIGITS-1:0] view_vals;
  logic [NUM_DIGITS-1:0]        view_en;
  logic [NUM_DIGITS-1:0]        supp;

  // On the first clock out of reset the snapshot is being loaded from the
  // live inputs, so present those directly instead of the stale zeros.
  assign view_vals = first_q ? digit_vals : snap_vals_q;
  assign view_en   = first_q ? digit_en   : snap_en_q;

  seg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .LZ_SUPPRESS(LZ_SUPPRESS)
  ) u_lz_mask (
    .codes   (view_vals),
    .en      (view_en),
    .suppress(supp)
  );

  always_comb begin
    logic off;
    slot_end  = (psc_q == PSC_LAST);
    take_snap = first_q | (slot_end & (idx_q == IDX_LAST));

    psc_d   = slot_end ? '0 : psc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    first_d     = 1'b0;
    snap_vals_d = take_snap ? digit_vals : snap_vals_q;
    snap_en_d   = take_snap ? digit_en   : snap_en_q;

    off           = (psc_q < PSC_BLANK) | supp[idx_q];
    cur_code_d    = view_vals[int'(idx_q)*CODE_W +: CODE_W];
    dig_sel_d     = off ? SEL_OFF : ~(NUM_DIGITS'(1) << idx_q);
    blank_d       = off;
    frame_start_d = (idx_q == '0) && (psc_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q         <= '0;
      idx_q         <= '0;
      first_q       <= 1'b1;
      snap_vals_q   <= '0;
      snap_en_q     <= '0;
      cur_code_q    <= '0;
      dig_sel_q     <= SEL_OFF;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      psc_q         <= psc_d;
      idx_q         <= idx_d;
      first_q       <= first_d;
      snap_vals_q   <= snap_vals_d;
      snap_en_q     <= snap_en_d;
      cur_code_q    <= cur_code_d;
      dig_sel_q     <= dig_sel_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cur_code    = cur_code_q;
  assign dig_sel     = dig_sel_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
